// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encodings, grant constants and defaults for wb_arb2.
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} arb_state_e;
  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0 = 2'b01;
  localparam logic [1:0] GNT_M1 = 2'b10;
  function automatic logic [1:0] grant_of(arb_state_e s);
    return s == OWN0 ? GNT_M0 : s == OWN1 ? GNT_M1 : GNT_NONE;
  endfunction
endpackage

// File: rtl/wb_arb_wdog.sv
// wb_arb_wdog: stall counter that flags a slave cycle left unacknowledged for LIMIT cycles.
module wb_arb_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic stall,
  input  logic clr,
  output logic expire
);
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    expire = cnt_q == 16'(LIMIT);
    cnt_d = (clr || expire) ? '0 : stall ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone classic arbiter, round-robin over whole cyc tenures.
// Optional slave watchdog built when WB_ARB_TIMEOUT_EN is defined.
module wb_arb2
  import wb_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DW-1:0] TIMEOUT_DATA = DW'(TIMEOUT_DATA_DEF)
) (
  input  logic          clk,
  input  logic          RESET_N,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack,
  output logic [1:0]    grant,
  output logic          timeout_pulse
);
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arb2: TIMEOUT_CYCLES must be in 1..65535");
  end
  arb_state_e state_q, state_d;
  logic last_q, last_d;
  logic [1:0] grant_q, grant_d;
  logic own0, own1, m_cyc, m_stb, wd_hit;
  logic [DW-1:0] rdata_x;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    case (state_q)
      IDLE: state_d = (m0_cyc && m1_cyc) ? (last_q ? OWN0 : OWN1) : m0_cyc ? OWN0 : m1_cyc ? OWN1 : IDLE;
      OWN0: if (!m0_cyc) begin
        last_d = 1'b0;
        state_d = m1_cyc ? OWN1 : IDLE;
      end
      OWN1: if (!m1_cyc) begin
        last_d = 1'b1;
        state_d = m0_cyc ? OWN0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
    grant_d = grant_of(state_d);
  end
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      grant_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      grant_q <= grant_d;
    end
  assign own0 = state_q == OWN0;
  assign own1 = state_q == OWN1;
  assign m_cyc = own0 ? m0_cyc : own1 & m1_cyc;
  assign m_stb = own0 ? m0_stb : own1 & m1_stb;
  assign s_cyc = m_cyc & ~wd_hit;
  assign s_stb = m_stb & ~wd_hit;
  assign s_we = own0 ? m0_we : own1 & m1_we;
  assign s_adr = own0 ? m0_adr : own1 ? m1_adr : '0;
  assign s_wdata = own0 ? m0_wdata : own1 ? m1_wdata : '0;
  assign rdata_x = wd_hit ? TIMEOUT_DATA : s_rdata;
  assign m0_ack = own0 & (s_ack | wd_hit);
  assign m1_ack = own1 & (s_ack | wd_hit);
  assign m0_rdata = own0 ? rdata_x : '0;
  assign m1_rdata = own1 ? rdata_x : '0;
  assign grant = grant_q;
  assign timeout_pulse = wd_hit;
`ifdef WB_ARB_TIMEOUT_EN
  logic wd_exp;
  wb_arb_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk(clk),
    .RESET_N(RESET_N),
    .stall(m_cyc & m_stb & ~s_ack),
    .clr(s_ack | (state_d != state_q)),
    .expire(wd_exp)
  );
  // A genuine ack in the expiry cycle wins over the synthetic one.
  assign wd_hit = wd_exp & ~s_ack;
`else
  assign wd_hit = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: vector table, directed corner sequences and random traffic against an owner/last model.
module tb_wb_arb2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO_CYC = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_cyc, m0_stb, m0_we, m0_ack, m1_cyc, m1_stb, m1_we, m1_ack;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic s_cyc, s_stb, s_we, s_ack, timeout_pulse;
  logic [1:0] grant;
  int total = 0;
  int passed = 0;
  int owner = -1;
  int last = 1;
  typedef struct {bit c0; bit c1; bit ack; logic [1:0] g;} vec_t;
  vec_t tbl[12];

  wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .RESET_N(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "tb_wb_arb2 timed out");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_in();
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
    {m0_adr, m1_adr, m0_wdata, m1_wdata, s_rdata} = '0;
  endtask

  // Expected outputs follow purely from who owns the bus this cycle.
  task automatic model_check();
    bit o0, o1;
    o0 = owner == 0;
    o1 = owner == 1;
    chk("grant", grant, o0 ? 2'b01 : o1 ? 2'b10 : 2'b00);
    chk("s_cyc", s_cyc, o0 ? m0_cyc : o1 ? m1_cyc : 1'b0);
    chk("s_stb", s_stb, o0 ? m0_stb : o1 ? m1_stb : 1'b0);
    chk("s_we", s_we, o0 ? m0_we : o1 ? m1_we : 1'b0);
    chk("s_adr", s_adr, o0 ? m0_adr : o1 ? m1_adr : '0);
    chk("s_wdata", s_wdata, o0 ? m0_wdata : o1 ? m1_wdata : '0);
    chk("m0_ack", m0_ack, o0 && s_ack);
    chk("m1_ack", m1_ack, o1 && s_ack);
    chk("m0_rdata", m0_rdata, o0 ? s_rdata : '0);
    chk("m1_rdata", m1_rdata, o1 ? s_rdata : '0);
    chk("timeout_pulse", timeout_pulse, 1'b0);
  endtask

  task automatic model_edge();
    logic [1:0] c;
    c = {m1_cyc, m0_cyc};
    if (owner < 0) owner = (c == 2'b11) ? 1 - last : c[0] ? 0 : c[1] ? 1 : -1;
    else if (!c[owner]) begin
      last = owner;
      owner = c[1-owner] ? 1 - owner : -1;
    end
  endtask

  task automatic cyc_end();
    #1;
    model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    owner = -1;
    last = 1;
  endtask

  initial begin
    int k, bad, stall;
    idle_in();
    tbl[0] = '{1, 1, 0, 2'b00};
    tbl[1] = '{1, 1, 1, 2'b01};
    tbl[2] = '{0, 1, 0, 2'b01};
    tbl[3] = '{0, 1, 1, 2'b10};
    tbl[4] = '{0, 0, 0, 2'b10};
    tbl[5] = '{1, 1, 0, 2'b00};
    tbl[6] = '{1, 1, 0, 2'b01};
    tbl[7] = '{0, 0, 0, 2'b01};
    tbl[8] = '{1, 1, 0, 2'b00};
    tbl[9] = '{1, 1, 0, 2'b10};
    tbl[10] = '{0, 0, 0, 2'b10};
    tbl[11] = '{0, 0, 0, 2'b00};
    #3;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_timeout", timeout_pulse, 1'b0);
    do_reset();
    // Round-robin ties, zero-gap handover and per-row acks.
    for (int i = 0; i < 12; i++) begin
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].c0; m0_we = 1'b1; m0_adr = 32'h100 + i; m0_wdata = i;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].c1; m1_we = 1'b1; m1_adr = 32'h200 + i; m1_wdata = 32'hA0 + i;
      s_ack = tbl[i].ack;
      #1;
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("tbl%0d_m0_ack", i), m0_ack, tbl[i].g == 2'b01 && tbl[i].ack);
      chk($sformatf("tbl%0d_m1_ack", i), m1_ack, tbl[i].g == 2'b10 && tbl[i].ack);
      cyc_end();
    end
    // Single master read with a two-cycle slave delay.
    idle_in();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h1000;
    #1;
    chk("rd_grant_latency", grant, 2'b00);
    cyc_end();
    #1;
    chk("rd_grant", grant, 2'b01);
    chk("rd_s_adr", s_adr, 32'h1000);
    cyc_end();
    cyc_end();
    s_ack = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    chk("rd_m0_ack", m0_ack, 1'b1);
    chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("rd_m1_ack", m1_ack, 1'b0);
    cyc_end();
    idle_in();
    cyc_end();
    // Tenure lock: m1 keeps the bus over four beats while m0 waits.
    m1_cyc = 1'b1;
    cyc_end();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m1_stb = i % 2 == 0; s_ack = m1_stb; s_rdata = 32'hC0DE_0000 + i;
      #1;
      chk($sformatf("lock%0d_grant", i), grant, 2'b10);
      chk($sformatf("lock%0d_m0_ack", i), m0_ack, 1'b0);
      cyc_end();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    cyc_end();
    #1;
    chk("lock_handover", grant, 2'b01);
    cyc_end();
    // Asynchronous reset in the middle of an acked beat.
    s_ack = 1'b1; s_rdata = 32'h5555_AAAA;
    #1;
    chk("mid_pre_ack", m0_ack, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_s_cyc", s_cyc, 1'b0);
    chk("mid_grant", grant, 2'b00);
    chk("mid_m0_ack", m0_ack, 1'b0);
    chk("mid_m1_ack", m1_ack, 1'b0);
    chk("mid_m0_rdata", m0_rdata, 32'h0);
    owner = -1; last = 1;
    idle_in();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_end();
    #1;
    chk("mid_release_grant", grant, 2'b10);
    cyc_end();
    // Random traffic with persistent cyc levels.
    stall = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
      m0_stb = $urandom_range(0, 1); m1_stb = $urandom_range(0, 1);
      m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
      m0_adr = $urandom; m1_adr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
      s_rdata = $urandom;
      s_ack = ($urandom_range(0, 1) == 1) || stall >= 4;
      stall = s_ack ? 0 : stall + 1;
      cyc_end();
    end
    idle_in();
    repeat (3) cyc_end();
    // Hung slave read with m1 waiting behind it.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h2000;
    cyc_end();
    chk("hung_owner_m0", owner, 0);
    m1_cyc = 1'b1; m1_stb = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
    k = 0;
    while (k < 20) begin
      #1;
      if (m0_ack) break;
      @(posedge clk);
      #1;
      k++;
    end
    chk("wd_cycles_to_expiry", k, TO_CYC);
    chk("wd_m0_ack", m0_ack, 1'b1);
    chk("wd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("wd_pulse", timeout_pulse, 1'b1);
    chk("wd_s_stb", s_stb, 1'b0);
    chk("wd_s_cyc", s_cyc, 1'b0);
    chk("wd_m1_ack", m1_ack, 1'b0);
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (m0_ack || m1_ack || timeout_pulse || grant !== 2'b01) bad++;
      @(posedge clk);
      #1;
    end
    chk("hung_bad_cycles", bad, 0);
    chk("hung_grant", grant, 2'b01);
    chk("hung_timeout", timeout_pulse, 1'b0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_arb2.md
# wb_arb2

Two-master Wishbone classic arbiter that shares one slave-side bus between masters m0 and m1 inside `soc_core`. It sits between the `m0_*`/`m1_*` master ports and the shared interconnect/slave decode, granting whole bus tenures (cyc-to-cyc) with round-robin fairness. An optional watchdog terminates slave cycles that never acknowledge.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT_CYCLES`, 255, watchdog limit in cycles (only with `WB_ARB_TIMEOUT_EN`); legal range 1..65535
- `TIMEOUT_DATA`, 32'hDEAD_BEEF, read data returned on a watchdog-terminated cycle

Ports:
- `clk` in 1: single clock, all state on rising edge
- `RESET_N` in 1: asynchronous, active-low reset
- `m0_cyc`, `m0_stb`, `m0_we` in 1 each: master 0 cycle, strobe, write enable
- `m0_adr` in AW; `m0_wdata` in DW: master 0 address and write data
- `m0_rdata` out DW; `m0_ack` out 1: master 0 read data and ack
- `m1_cyc`, `m1_stb`, `m1_we`, `m1_adr`, `m1_wdata`, `m1_rdata`, `m1_ack`: same as m0, for master 1
- `s_cyc`, `s_stb`, `s_we` out 1 each: shared slave cycle, strobe, write enable
- `s_adr` out AW; `s_wdata` out DW: shared slave address and write data
- `s_rdata` in DW; `s_ack` in 1: shared slave read data and ack
- `grant` out 2: one-hot current owner; bit0 = m0, bit1 = m1; 2'b00 when idle
- `timeout_pulse` out 1: one-cycle flag on watchdog expiry; tied 0 without the macro

## Operation
- FSM states: IDLE, OWN0, OWN1. State and `last_owner` (1 bit, m0 = 0) are registered.
- IDLE:
  - Only m0_cyc asserted -> OWN0. Only m1_cyc asserted -> OWN1.
  - Both asserted -> grant the master that is not `last_owner`.
  - After reset `last_owner` = 1, so m0 wins the first tie.
- OWNx:
  - Slave outputs are a combinational mux of master x: `s_cyc` = mx_cyc, `s_stb` = mx_stb, and we/adr/wdata from mx.
  - `mx_ack` = `s_ack`; `mx_rdata` = `s_rdata`.
  - Non-owner ack = 0 and rdata = 0.
- Release:
  - In OWNx with mx_cyc = 0: `last_owner` <= x.
  - If the other master's cyc = 1, go directly to OWN(other), with no idle cycle. Otherwise go to IDLE.
- The owner keeps the bus for its whole cyc tenure, including multiple stb beats. There is no preemption.
- Idle slave outputs: cyc/stb/we = 0, adr/wdata = 0.
- Reset (async, any state, including mid-cycle):
  - State = IDLE, `last_owner` = 1.
  - Outputs: `grant` = 0, all acks = 0, all rdata = 0, `s_*` = 0, `timeout_pulse` = 0.

## Timing
- Grant latency: cyc asserted at edge N (arbiter IDLE) -> state OWNx after edge N+1. `s_cyc` follows combinationally in cycle N+1, so there is one cycle of arbitration latency.
- Handover: owner drops cyc in cycle K -> the other master is owner from cycle K+1. There is zero dead cycles between tenures.
- Data path: `s_ack` -> `mx_ack` and `s_rdata` -> `mx_rdata` are combinational, adding zero latency.
- `grant` is registered and equals the state one-hot.
- If a master drops cyc in the same cycle an ack arrives, the ack is still forwarded that cycle. Release takes effect at the next edge.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- With the macro, a 16-bit `wd_cnt` is active:
  - It increments each cycle with `s_cyc & s_stb & ~s_ack`.
  - It clears on `s_ack`, on any state change, and on reset.
  - When `wd_cnt == TIMEOUT_CYCLES`, for one cycle the arbiter:
    - forces `mx_ack` = 1 and `mx_rdata` = TIMEOUT_DATA to the owner,
    - forces `s_cyc` = `s_stb` = 0,
    - pulses `timeout_pulse`,
    - clears the counter.
  - A real `s_ack` in that same cycle takes precedence: the real data is forwarded and there is no timeout pulse.
- Without the macro, no counter is built. A non-acking slave holds the bus indefinitely, and `timeout_pulse` = 0.

## Structure
- Shared package/header `wb_arb_pkg`:
  - state encodings (IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2),
  - `TIMEOUT_DATA` default,
  - grant one-hot constants.
- One natural sub-module, `wb_arb_wdog`, holds the watchdog counter. It is instantiated only under `WB_ARB_TIMEOUT_EN`.

## Test plan
- **Reset mid-cycle:**
  - Stimulus: m0 owns the bus with stb high; assert `RESET_N` = 0 asynchronously between edges.
  - Required: `s_cyc`, `grant`, and both acks drop to 0 immediately.
  - Required after release: with m1_cyc high, `grant` = 2'b10 one cycle later.
- **Single master read:**
  - Stimulus: m0 reads adr 0x1000 and the slave acks 2 cycles later with 0x12345678.
  - Required: `grant` = 01 one cycle after cyc; m0_rdata = 0x12345678 with m0_ack; m1_ack stays 0.
- **Simultaneous requests, round-robin:**
  - Stimulus: m0 and m1 both raise cyc from IDLE after reset and each does 1 write.
  - Required: m0 served first; m1 granted in the cycle after m0_cyc falls (zero gap); on the next tie, m1 does not win.
- **Tenure lock:**
  - Stimulus: m1 holds cyc across 4 stb beats while m0 requests.
  - Required: m0 never sees ack and `grant` stays 10 until m1_cyc = 0.
- **Watchdog expiry (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8):**
  - Stimulus: m0 reads and the slave never acks.
  - Required: on cycle 8 of stb, m0_ack = 1, m0_rdata = 0xDEADBEEF, `timeout_pulse` = 1, `s_stb` = 0.
- **Macro off:**
  - Stimulus: the same hung read as the watchdog case.
  - Required: no ack after 1000 cycles; `timeout_pulse` stays 0; m1 remains blocked.
